// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

  // Scan scheduler states: all digits dark, or one digit driven.
  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

  // Register offsets from the bus base address.
  localparam logic [1:0] OFS_D10   = 2'd0;  // {digit1, digit0}
  localparam logic [1:0] OFS_D32   = 2'd1;  // {digit3, digit2}
  localparam logic [1:0] OFS_DOT   = 2'd2;  // [3:0] dot mask, 1 = dot on
  localparam logic [1:0] OFS_BLANK = 2'd3;  // [3:0] blank mask, 1 = digit dark

  // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex digit to active-low seven-segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped four-digit seven-segment scan controller. CPU writes land in
// shadow registers and are copied to the displayed set only at frame ends.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'hD0,
  parameter int         SCAN_DIV     = 50000,
  parameter int         BLANK_CYCLES = 500
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA_IN,
  input  logic       BUS_WE,
  output logic [3:0] SEG_SELECT_OUT,
  output logic [7:0] HEX_OUT,
  output logic       FRAME_DONE,
  output logic       COMMIT_PEND
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             frame_end;

  logic [7:0] sh_d10, sh_d32, act_d10, act_d32;
  logic [3:0] sh_dot, sh_blank, act_dot, act_blank;

  logic [8:0] bus_ofs;
  logic       bus_hit;
  logic [3:0] digit;
  logic [6:0] seg;
  logic [3:0] sel_d;
  logic [7:0] hex_d;

  // Borrow into bit 8 makes addresses below the base fall out of range.
  assign bus_ofs = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
  assign bus_hit = BUS_WE && (bus_ofs < 9'd4);

  // Shadow capture of CPU writes and atomic commit to the active set at frame end.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking (<=) so every register samples pre-edge values; with
    // blocking, the commit below could copy a same-cycle write.
    if (RESET) begin
      sh_d10      <= '0;
      sh_d32      <= '0;
      sh_dot      <= '0;
      sh_blank    <= 4'hF;
      act_d10     <= '0;
      act_d32     <= '0;
      act_dot     <= '0;
      act_blank   <= 4'hF;
      COMMIT_PEND <= 1'b0;
    end else begin
      if (frame_end && COMMIT_PEND) begin
        act_d10     <= sh_d10;
        act_d32     <= sh_d32;
        act_dot     <= sh_dot;
        act_blank   <= sh_blank;
        COMMIT_PEND <= 1'b0;
      end
      // A write in the commit cycle lands after the copy and stays pending.
      if (bus_hit) begin
        case (bus_ofs[1:0])
          OFS_D10:   sh_d10   <= BUS_DATA_IN;
          OFS_D32:   sh_d32   <= BUS_DATA_IN;
          OFS_DOT:   sh_dot   <= BUS_DATA_IN[3:0];
          default:   sh_blank <= BUS_DATA_IN[3:0];
        endcase
        COMMIT_PEND <= 1'b1;
      end
    end
  end

  // Scan scheduler state, slot counter and digit index.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Pick the active digit nibble for the current index.
  always_comb begin
    digit = act_d10[3:0];
    case (idx)
      2'd0:    digit = act_d10[3:0];
      2'd1:    digit = act_d10[7:4];
      2'd2:    digit = act_d32[3:0];
      default: digit = act_d32[7:4];
    endcase
  end

  seg7_decoder u_decoder (
    .hex (digit),
    .seg (seg)
  );

  // Next-state logic plus the pre-register pin values for the current slot.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    frame_end = 1'b0;
    sel_d     = 4'hF;
    hex_d     = 8'hFF;
    case (state)
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = S_DRIVE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (!act_blank[idx]) begin
          sel_d = ~(4'b0001 << idx);
          hex_d = {~act_dot[idx], seg};
        end
        if (cnt == DRIVE_LAST) begin
          state_nxt = S_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
          frame_end = (idx == 2'd3);
        end
      end
    endcase
  end

  // Registered display pins, one cycle behind the scheduler.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEG_SELECT_OUT <= 4'hF;
      HEX_OUT        <= 8'hFF;
    end else begin
      SEG_SELECT_OUT <= sel_d;
      HEX_OUT        <= hex_d;
    end
  end

  // Frame-done is decoded from registered state only, so it coincides with the commit cycle.
  assign FRAME_DONE = frame_end;

endmodule
